// File: rtl/dms_vco_cal_pkg.sv
// Shared definitions for the VCO gain calibration sequencer.
// Holds the sequencer state encoding, the DAC voltage scale
// (Vcntrl = V_MIN_MV + V_STEP_MV * code), the default parameter values
// and the code-to-table-index mapping (index 0 is the highest voltage).
package dms_vco_cal_pkg;

  localparam int unsigned DEF_NUM_PTS    = 161;
  localparam int unsigned DEF_SETTLE_CYC = 64;
  localparam int unsigned DEF_WIN_CYC    = 1024;
  localparam int unsigned DEF_CNT_W      = 16;
  localparam int unsigned DEF_DATA_W     = 64;

  localparam int unsigned V_MIN_MV  = 400;
  localparam int unsigned V_STEP_MV = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEAS,
    ST_CALC,
    ST_WR,
    ST_WR2,
    ST_FIN
  } state_e;

  // The table is ordered from high voltage to low voltage, so the index
  // runs opposite to the DAC code.
  function automatic logic [7:0] addr_from_code(input logic [7:0] code,
                                                input int unsigned num_pts);
    return 8'(num_pts - 1) - code;
  endfunction

endpackage

// File: rtl/dms_vco_edge_cnt.sv
// Windowed saturating edge counter.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_clr          synchronous clear of count, window position and sat flag
//   i_en           window open; each enabled cycle advances the window
//   i_edge         one-cycle VCO edge pulse (counted only while i_en)
//   o_count        edges counted in the current window
//   o_sat          an edge arrived while the count was already full-scale
//   o_win_done     high on the last cycle of the window (combinational)
module dms_vco_edge_cnt
  import dms_vco_cal_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned WIN_CYC = DEF_WIN_CYC
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_edge,
  output logic [CNT_W-1:0] o_count,
  output logic             o_sat,
  output logic             o_win_done
);

  localparam int unsigned WIN_W = $clog2(WIN_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIN_W-1:0] r_win;

  // The edge on the final window cycle is still accumulated on the same
  // clock edge that ends the window, so the count is complete one cycle later.
  assign o_win_done = i_en && (r_win == WIN_W'(WIN_CYC - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_win   <= '0;
      o_count <= '0;
      o_sat   <= 1'b0;
    end else if (i_clr) begin
      r_win   <= '0;
      o_count <= '0;
      o_sat   <= 1'b0;
    end else if (i_en) begin
      r_win <= r_win + WIN_W'(1);
      if (i_edge) begin
        if (o_count == CNT_MAX) begin
          o_sat <= 1'b1;
        end else begin
          o_count <= o_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/dms_vco_gain_cal.sv
// VCO gain calibration sequencer (writer side of the VCO gain table).
// Sweeps the DAC code 0..NUM_PTS-1, counts VCO edges over a fixed window at
// each code and writes the count difference to the previous code as the gain
// entry at index (NUM_PTS-1)-code. The lowest entry duplicates the first
// measured difference.
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_start            pulse; begins a sweep when idle
//   i_abort            pulse; cancels a sweep (wins over i_start)
//   i_vco_edge         synchronised VCO edge pulse
//   o_dac_code         DAC control code, o_dac_valid while it drives the VCO
//   o_lut_we/addr/wdata  table write port
//   o_busy, o_done     sweep in progress / normal completion pulse
//   o_err_nonmono      sticky: a negative delta was clamped to 0
//   o_err_ovf          sticky: the edge counter saturated
module dms_vco_gain_cal
  import dms_vco_cal_pkg::*;
#(
  parameter int unsigned NUM_PTS    = DEF_NUM_PTS,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned WIN_CYC    = DEF_WIN_CYC,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned DATA_W     = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_vco_edge,
  output logic [7:0]        o_dac_code,
  output logic              o_dac_valid,
  output logic              o_lut_we,
  output logic [7:0]        o_lut_addr,
  output logic [DATA_W-1:0] o_lut_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_nonmono,
  output logic              o_err_ovf
);

  localparam int unsigned TMR_W     = $clog2(SETTLE_CYC + 1);
  localparam logic [7:0]  LAST_CODE = 8'(NUM_PTS - 1);

  state_e                r_state;
  logic [TMR_W-1:0]      r_tmr;
  logic [CNT_W-1:0]      r_prev;
  logic [CNT_W-1:0]      w_count;
  logic                  w_sat;
  logic                  w_win_done;
  logic                  w_en;
  logic                  w_clr;
  logic signed [CNT_W:0] w_delta;
  logic [DATA_W-1:0]     w_wdata;

  // The counter is held clear outside MEAS, so every window starts at zero
  // and edges outside the window never reach it.
  assign w_en  = (r_state == ST_MEAS);
  assign w_clr = !w_en;

  dms_vco_edge_cnt #(
    .CNT_W   (CNT_W),
    .WIN_CYC (WIN_CYC)
  ) u_edge_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (w_clr),
    .i_en       (w_en),
    .i_edge     (i_vco_edge),
    .o_count    (w_count),
    .o_sat      (w_sat),
    .o_win_done (w_win_done)
  );

  assign w_delta = $signed({1'b0, w_count}) - $signed({1'b0, r_prev});
  // Negative gain is physically meaningless here; clamp it to zero.
  assign w_wdata = w_delta[CNT_W] ? '0 : DATA_W'(w_delta[CNT_W-1:0]);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_tmr         <= '0;
      r_prev        <= '0;
      o_dac_code    <= '0;
      o_dac_valid   <= 1'b0;
      o_lut_we      <= 1'b0;
      o_lut_addr    <= '0;
      o_lut_wdata   <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err_nonmono <= 1'b0;
      o_err_ovf     <= 1'b0;
    end else if (i_abort && (r_state != ST_IDLE)) begin
      r_state     <= ST_IDLE;
      o_dac_code  <= '0;
      o_dac_valid <= 1'b0;
      o_lut_we    <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          o_done   <= 1'b0;
          o_lut_we <= 1'b0;
          if (i_start && !i_abort) begin
            r_state       <= ST_SETTLE;
            r_tmr         <= '0;
            o_dac_code    <= '0;
            o_dac_valid   <= 1'b1;
            o_busy        <= 1'b1;
            o_err_nonmono <= 1'b0;
            o_err_ovf     <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (r_tmr == TMR_W'(SETTLE_CYC - 1)) begin
            r_tmr   <= '0;
            r_state <= ST_MEAS;
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end
        ST_MEAS: begin
          if (w_win_done) r_state <= ST_CALC;
        end
        ST_CALC: begin
          r_prev <= w_count;
          if (w_sat) o_err_ovf <= 1'b1;
          if (o_dac_code == 8'd0) begin
            o_dac_code <= o_dac_code + 8'd1;
            r_tmr      <= '0;
            r_state    <= ST_SETTLE;
          end else begin
            if (w_delta[CNT_W]) o_err_nonmono <= 1'b1;
            o_lut_we    <= 1'b1;
            o_lut_addr  <= addr_from_code(o_dac_code, NUM_PTS);
            o_lut_wdata <= w_wdata;
            r_state     <= ST_WR;
          end
        end
        ST_WR: begin
          if (o_dac_code == 8'd1) begin
            // Code 0 has no delta of its own, so the lowest-voltage entry
            // reuses the first measured gain; write strobe stays high.
            o_lut_addr <= LAST_CODE;
            r_state    <= ST_WR2;
          end else begin
            o_lut_we <= 1'b0;
            if (o_dac_code == LAST_CODE) begin
              o_done      <= 1'b1;
              o_busy      <= 1'b0;
              o_dac_valid <= 1'b0;
              o_dac_code  <= '0;
              r_state     <= ST_FIN;
            end else begin
              o_dac_code <= o_dac_code + 8'd1;
              r_tmr      <= '0;
              r_state    <= ST_SETTLE;
            end
          end
        end
        ST_WR2: begin
          o_lut_we <= 1'b0;
          if (o_dac_code == LAST_CODE) begin
            o_done      <= 1'b1;
            o_busy      <= 1'b0;
            o_dac_valid <= 1'b0;
            o_dac_code  <= '0;
            r_state     <= ST_FIN;
          end else begin
            o_dac_code <= o_dac_code + 8'd1;
            r_tmr      <= '0;
            r_state    <= ST_SETTLE;
          end
        end
        ST_FIN: begin
          o_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dms_vco_gain_cal.sv
// Directed testbench for dms_vco_gain_cal, run with a reduced sweep
// (20 points, 4 settle cycles, 80-cycle window, 6-bit counter).
module tb_dms_vco_gain_cal;

  localparam int N  = 20;
  localparam int S  = 4;
  localparam int W  = 80;
  localparam int CW = 6;
  localparam int DW = 64;
  // N*(S+W+1) + N + 1 with the reduced parameters
  localparam int EXP_DONE_CYC = 1721;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          vco_edge = 1'b0;
  logic [7:0]    dac_code, lut_addr;
  logic          dac_valid, lut_we, busy, done, err_nonmono, err_ovf;
  logic [DW-1:0] lut_wdata;

  dms_vco_gain_cal #(
    .NUM_PTS(N), .SETTLE_CYC(S), .WIN_CYC(W), .CNT_W(CW), .DATA_W(DW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_vco_edge(vco_edge), .o_dac_code(dac_code), .o_dac_valid(dac_valid),
    .o_lut_we(lut_we), .o_lut_addr(lut_addr), .o_lut_wdata(lut_wdata),
    .o_busy(busy), .o_done(done), .o_err_nonmono(err_nonmono),
    .o_err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // VCO model: 0 linear (edges at window end), 1 dip at code 10 (edges at
  // window start), 2 an edge every cycle.
  int         mode = 0;
  int         phase = 0;
  logic       busy_q = 1'b0;
  logic [7:0] code_q = 8'd0;

  function automatic int edges_for(input int code, input int m);
    if (m == 1 && code == 10) return 20;
    return 10 + 2 * code;
  endfunction

  // Phase 1 is the first SETTLE cycle of a code; MEAS spans S+1..S+W.
  // Extra edges at phase S (SETTLE) and S+W+1 (CALC) must be ignored.
  initial begin
    int e;
    forever begin
      @(posedge clk);
      #1;
      if ((busy && !busy_q) || (dac_code != code_q)) phase = 1;
      else phase = phase + 1;
      busy_q = busy;
      code_q = dac_code;
      e = edges_for(int'(dac_code), mode);
      case (mode)
        0: vco_edge = (phase > S + W - e && phase <= S + W) || phase == S || phase == S + W + 1;
        1: vco_edge = (phase > S && phase <= S + e) || phase == S || phase == S + W + 1;
        default: vco_edge = 1'b1;
      endcase
    end
  end

  // Write / done log
  int            wr_cnt[256];
  logic [DW-1:0] wr_data[256];
  int            total_wr = 0, consec_bad = 0, done_cnt = 0, cyc = 0, done_cyc = 0;
  logic          mon_busy_q = 1'b0, we_q = 1'b0;
  logic [7:0]    prev_addr = 8'd0;

  always @(negedge clk) begin
    if (busy && !mon_busy_q) cyc = 1;
    else cyc = cyc + 1;
    mon_busy_q = busy;
    if (lut_we) begin
      wr_cnt[lut_addr]  = wr_cnt[lut_addr] + 1;
      wr_data[lut_addr] = lut_wdata;
      total_wr = total_wr + 1;
      if (we_q && !(prev_addr == 8'(N - 2) && lut_addr == 8'(N - 1)))
        consec_bad = consec_bad + 1;
      $display("write addr=%0d wdata=%0d code=%0d", lut_addr, lut_wdata, dac_code);
    end
    we_q      = lut_we;
    prev_addr = lut_addr;
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      $display("done at cycle %0d nonmono=%0b ovf=%0b", cyc, err_nonmono, err_ovf);
    end
  end

  int base_cnt[256];
  int base_total, base_done, base_consec;

  task automatic snap();
    base_total  = total_wr;
    base_done   = done_cnt;
    base_consec = consec_bad;
    for (int i = 0; i < 256; i++) base_cnt[i] = wr_cnt[i];
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input bit start_on_fin, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk); #1;
      if (done) begin
        ok = 1'b1;
        if (start_on_fin) begin
          start = 1'b1;
          @(posedge clk); #1 start = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_meas(input int code, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (busy && dac_code == 8'(code) && phase == S + 10) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({dac_code, dac_valid, lut_we, lut_addr, lut_wdata, busy, done, err_nonmono, err_ovf} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got busy=%0b code=%0d we=%0b exp all zero", busy, dac_code, lut_we);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("reset checked");
  endtask

  task automatic test_linear();
    bit ok;
    mode = 0;
    snap();
    do_start();
    wait_done(1'b0, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL linear_done got=timeout exp=done"); end
    n_checks++;
    if (done_cyc !== EXP_DONE_CYC) begin n_fail++; $display("FAIL linear_done_cycle got=%0d exp=%0d", done_cyc, EXP_DONE_CYC); end
    n_checks++;
    if (total_wr - base_total !== N) begin n_fail++; $display("FAIL linear_writes got=%0d exp=%0d", total_wr - base_total, N); end
    for (int a = 0; a < N; a++) begin
      n_checks++;
      if (wr_cnt[a] - base_cnt[a] !== 1) begin n_fail++; $display("FAIL linear_addr_count addr=%0d got=%0d exp=1", a, wr_cnt[a] - base_cnt[a]); end
      n_checks++;
      if (wr_data[a] !== 64'd2) begin n_fail++; $display("FAIL linear_wdata addr=%0d got=%0d exp=2", a, wr_data[a]); end
    end
    n_checks++;
    if (consec_bad - base_consec !== 0) begin n_fail++; $display("FAIL linear_we_back_to_back got=%0d exp=0", consec_bad - base_consec); end
    n_checks++;
    if ({err_nonmono, err_ovf} !== 2'b00) begin n_fail++; $display("FAIL linear_errors got=%b exp=00", {err_nonmono, err_ovf}); end
    n_checks++;
    if ({busy, dac_valid, dac_code} !== 10'd0) begin n_fail++; $display("FAIL linear_fin_outputs got busy=%0b valid=%0b code=%0d exp 0", busy, dac_valid, dac_code); end
    $display("linear sweep checked");
  endtask

  task automatic test_nonmono();
    bit ok;
    mode = 1;
    snap();
    do_start();
    wait_done(1'b0, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL dip_done got=timeout exp=done"); end
    n_checks++;
    if (wr_data[9] !== 64'd0) begin n_fail++; $display("FAIL dip_clamped_wdata got=%0d exp=0", wr_data[9]); end
    n_checks++;
    if (wr_data[8] !== 64'd12) begin n_fail++; $display("FAIL dip_recovery_wdata got=%0d exp=12", wr_data[8]); end
    n_checks++;
    if (wr_data[19] !== 64'd2) begin n_fail++; $display("FAIL dip_lowest_wdata got=%0d exp=2", wr_data[19]); end
    repeat (5) @(negedge clk);
    n_checks++;
    if ({err_nonmono, err_ovf} !== 2'b10) begin n_fail++; $display("FAIL dip_errors got=%b exp=10", {err_nonmono, err_ovf}); end
    // the next accepted start clears the flag
    mode = 0;
    do_start();
    @(negedge clk);
    n_checks++;
    if (err_nonmono !== 1'b0) begin n_fail++; $display("FAIL dip_flag_clear got=%0b exp=0", err_nonmono); end
    wait_done(1'b0, ok);
    n_checks++;
    if ({ok, err_nonmono} !== 2'b10) begin n_fail++; $display("FAIL dip_resweep got ok=%0b nonmono=%0b exp 1/0", ok, err_nonmono); end
    $display("non-monotonic sweep checked");
  endtask

  task automatic test_overflow();
    bit ok;
    mode = 2;
    snap();
    do_start();
    wait_done(1'b0, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL ovf_done got=timeout exp=done"); end
    n_checks++;
    if ({err_ovf, err_nonmono} !== 2'b10) begin n_fail++; $display("FAIL ovf_errors got=%b exp=10", {err_ovf, err_nonmono}); end
    n_checks++;
    if (total_wr - base_total !== N) begin n_fail++; $display("FAIL ovf_writes got=%0d exp=%0d", total_wr - base_total, N); end
    for (int a = 0; a < N; a++) begin
      n_checks++;
      if (wr_data[a] !== 64'd0) begin n_fail++; $display("FAIL ovf_wdata addr=%0d got=%0d exp=0", a, wr_data[a]); end
    end
    $display("overflow sweep checked");
  endtask

  task automatic test_abort();
    bit ok;
    mode = 2;
    snap();
    do_start();
    wait_meas(7, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL abort_reach_code7 got=timeout exp=meas"); end
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, dac_valid, dac_code, lut_we} !== 11'd0) begin
      n_fail++; $display("FAIL abort_outputs got busy=%0b valid=%0b code=%0d we=%0b exp 0", busy, dac_valid, dac_code, lut_we);
    end
    n_checks++;
    if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL abort_flag_retained got=%0b exp=1", err_ovf); end
    snap();
    repeat (300) @(negedge clk);
    n_checks++;
    if ({total_wr - base_total, done_cnt - base_done} !== {32'd0, 32'd0}) begin
      n_fail++; $display("FAIL abort_quiet got writes=%0d dones=%0d exp 0/0", total_wr - base_total, done_cnt - base_done);
    end
    $display("abort checked");
  endtask

  task automatic test_start_ignored();
    bit ok;
    mode = 0;
    snap();
    do_start();
    for (int i = 0; i < 3000 && !(dac_code == 8'd10 && phase == 2); i++) @(negedge clk);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, dac_valid, dac_code} !== {2'b11, 8'd10}) begin
      n_fail++; $display("FAIL start_mid_sweep got busy=%0b valid=%0b code=%0d exp 1/1/10", busy, dac_valid, dac_code);
    end
    wait_done(1'b1, ok);
    n_checks++;
    if ({ok, 32'(done_cyc), 32'(total_wr - base_total)} !== {1'b1, 32'(EXP_DONE_CYC), 32'(N)}) begin
      n_fail++; $display("FAIL start_ignored_sweep got ok=%0b cyc=%0d writes=%0d exp 1/%0d/%0d", ok, done_cyc, total_wr - base_total, EXP_DONE_CYC, N);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if ({busy, dac_valid} !== 2'b00) begin n_fail++; $display("FAIL start_on_fin got busy=%0b valid=%0b exp 0/0", busy, dac_valid); end
    // abort and start together in IDLE: nothing starts
    @(posedge clk); #1 begin start = 1'b1; abort = 1'b1; end
    @(posedge clk); #1 begin start = 1'b0; abort = 1'b0; end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, dac_valid} !== 2'b00) begin n_fail++; $display("FAIL abort_beats_start got busy=%0b valid=%0b exp 0/0", busy, dac_valid); end
    $display("ignored starts checked");
  endtask

  task automatic test_reset_midsweep();
    bit ok;
    mode = 0;
    do_start();
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk); #1;
      if (lut_we && lut_addr == 8'(N - 1 - 9)) ok = 1'b1;
    end
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL rst_reach_code9 got=timeout exp=write"); end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({dac_code, dac_valid, lut_we, lut_addr, lut_wdata, busy, done, err_nonmono, err_ovf} !== '0) begin
      n_fail++; $display("FAIL rst_async_outputs got busy=%0b code=%0d we=%0b exp all zero", busy, dac_code, lut_we);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    snap();
    repeat (50) @(negedge clk);
    n_checks++;
    if ({total_wr - base_total, 32'(busy)} !== {32'd0, 32'd0}) begin
      n_fail++; $display("FAIL rst_quiet got writes=%0d busy=%0b exp 0/0", total_wr - base_total, busy);
    end
    snap();
    do_start();
    wait_done(1'b0, ok);
    n_checks++;
    if ({ok, 32'(total_wr - base_total)} !== {1'b1, 32'(N)}) begin
      n_fail++; $display("FAIL rst_resweep got ok=%0b writes=%0d exp 1/%0d", ok, total_wr - base_total, N);
    end
    for (int a = 0; a < N; a++) begin
      n_checks++;
      if (wr_cnt[a] - base_cnt[a] !== 1) begin n_fail++; $display("FAIL rst_resweep_addr addr=%0d got=%0d exp=1", a, wr_cnt[a] - base_cnt[a]); end
    end
    $display("mid-sweep reset checked");
  endtask

  initial begin
    test_reset();
    test_linear();
    test_nonmono();
    test_overflow();
    test_abort();
    test_start_ignored();
    test_reset_midsweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
